cmac_rx_frame_buffer: RTL and testbench

Sits directly downstream of the CMAC control stage, on its gated `rx_out` AXI-Stream, which carries no backpressure. Realigns the stream to frame boundaries after reset or silence gating and buffers beats in a small FIFO so the application can apply `tready`. On overflow it truncates or drops whole frames instead of corrupting them. Optional statistics counters report good, bad and dropped frames.

---
 rtl/cmac_rx_pkg.sv | 21 ++
 rtl/cmac_rx_sync_fifo.sv | 48 ++++
 rtl/cmac_rx_frame_buffer.sv | 145 ++++++++++++++
 tb/tb_cmac_rx_frame_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_rx_pkg.sv
// Shared widths, frame-state encoding and the beat record for the CMAC rx frame buffer.
package cmac_rx_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = 64;
    localparam int STAT_W      = 32;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
        logic                   user;
    } axis_beat_t;

endpackage

// File: rtl/cmac_rx_sync_fifo.sv
// Single-clock beat FIFO with registered occupancy; head is visible the cycle after the write.
// The read side presents zeros while empty, so the payload is clean out of reset.
module cmac_rx_sync_fifo
    import cmac_rx_pkg::*;
#(
    parameter int   DEPTH = 16,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic       rx_clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  axis_beat_t wr_beat,
    input  logic       rd_en,
    output axis_beat_t rd_beat,
    output logic       empty,
    output logic [AW:0] count
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    axis_beat_t  mem [DEPTH];

    // One extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    always_ff @(posedge rx_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_beat;
    end

    assign rd_beat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cmac_rx_frame_buffer.sv
// Frame-aligning rx buffer: drops or truncates whole frames on overflow; 1-cycle latency to out_*.
// Input has no backpressure; out_tready drains the FIFO. Counters exist only with CMAC_RX_STATS_EN.
module cmac_rx_frame_buffer
    import cmac_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   rx_clk,
    input  logic                   resetn,
    input  logic [AXIS_DATA_W-1:0] in_tdata,
    input  logic [AXIS_KEEP_W-1:0] in_tkeep,
    input  logic                   in_tlast,
    input  logic                   in_tuser,
    input  logic                   in_tvalid,
    output logic [AXIS_DATA_W-1:0] out_tdata,
    output logic [AXIS_KEEP_W-1:0] out_tkeep,
    output logic                   out_tlast,
    output logic                   out_tuser,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   overflow
`ifdef CMAC_RX_STATS_EN
    ,
    output logic [STAT_W-1:0]      good_frames,
    output logic [STAT_W-1:0]      bad_frames,
    output logic [STAT_W-1:0]      dropped_frames
`endif
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    rx_state_e   state, state_nxt;
    logic        sof, sof_nxt;
    logic        wr_en;
    logic        drop_ev;
    logic        room;
    axis_beat_t  wr_beat;
    axis_beat_t  rd_beat;
    logic        empty;
    logic [AW:0] count;
    logic [AW:0] free;

    // Occupancy is the registered value, so a same-cycle read never credits free space.
    assign free = DEPTH_C - count;
    assign room = (free >= TWO_C) || ((free >= ONE_C) && in_tlast);

    always_comb begin
        state_nxt = state;
        sof_nxt   = sof;
        wr_en     = 1'b0;
        drop_ev   = 1'b0;
        wr_beat   = '{data: in_tdata, keep: in_tkeep, last: in_tlast, user: in_tuser};
        if (in_tvalid) begin
            case (state)
                SEEK: begin
                    if (in_tlast) begin
                        state_nxt = PASS;
                        sof_nxt   = 1'b1;
                    end
                end
                PASS: begin
                    if (room) begin
                        wr_en   = 1'b1;
                        sof_nxt = in_tlast;
                    end else if (sof) begin
                        drop_ev = 1'b1;
                        if (!in_tlast)
                            state_nxt = DROP;
                    end else begin
                        // One slot left mid-frame: close the frame as errored there.
                        wr_en        = (free != '0);
                        wr_beat.last = 1'b1;
                        wr_beat.user = 1'b1;
                        drop_ev      = 1'b1;
                        sof_nxt      = 1'b1;
                        state_nxt    = DROP;
                    end
                end
                DROP: begin
                    if (in_tlast) begin
                        state_nxt = PASS;
                        sof_nxt   = 1'b1;
                    end
                end
                default: state_nxt = SEEK;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge resetn) begin
        if (!resetn) begin
            state    <= SEEK;
            sof      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            sof      <= sof_nxt;
            overflow <= drop_ev;
        end
    end

`ifdef CMAC_RX_STATS_EN
    logic good_inc, bad_inc;
    assign good_inc = wr_en && wr_beat.last && !wr_beat.user;
    assign bad_inc  = wr_en && in_tlast && in_tuser && !drop_ev;

    always_ff @(posedge rx_clk or negedge resetn) begin
        if (!resetn) begin
            good_frames    <= '0;
            bad_frames     <= '0;
            dropped_frames <= '0;
        end else begin
            if (good_inc && (good_frames != '1))
                good_frames <= good_frames + 1'b1;
            if (bad_inc && (bad_frames != '1))
                bad_frames <= bad_frames + 1'b1;
            if (drop_ev && (dropped_frames != '1))
                dropped_frames <= dropped_frames + 1'b1;
        end
    end
`endif

    cmac_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .rx_clk  (rx_clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_beat (wr_beat),
        .rd_en   (out_tready),
        .rd_beat (rd_beat),
        .empty   (empty),
        .count   (count)
    );

    assign out_tvalid = !empty;
    assign out_tdata  = rd_beat.data;
    assign out_tkeep  = rd_beat.keep;
    assign out_tlast  = rd_beat.last;
    assign out_tuser  = rd_beat.user;

endmodule

// File: tb/tb_cmac_rx_frame_buffer.sv
// Directed and random traffic against a queue-based frame model of the rx buffer.
module tb_cmac_rx_frame_buffer;
    import cmac_rx_pkg::*;

    localparam int DEPTH = 16;

    logic                   rx_clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [AXIS_DATA_W-1:0] in_tdata = '0;
    logic [AXIS_KEEP_W-1:0] in_tkeep = '0;
    logic                   in_tlast = 1'b0;
    logic                   in_tuser = 1'b0;
    logic                   in_tvalid = 1'b0;
    logic [AXIS_DATA_W-1:0] out_tdata;
    logic [AXIS_KEEP_W-1:0] out_tkeep;
    logic                   out_tlast;
    logic                   out_tuser;
    logic                   out_tvalid;
    logic                   out_tready = 1'b1;
    logic                   overflow;
`ifdef CMAC_RX_STATS_EN
    logic [STAT_W-1:0]      good_frames, bad_frames, dropped_frames;
`endif

    always #5 rx_clk = ~rx_clk;

    cmac_rx_frame_buffer #(.FIFO_DEPTH(DEPTH)) dut (
        .rx_clk     (rx_clk),
        .resetn     (resetn),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tlast   (in_tlast),
        .in_tuser   (in_tuser),
        .in_tvalid  (in_tvalid),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast),
        .out_tuser  (out_tuser),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .overflow   (overflow)
`ifdef CMAC_RX_STATS_EN
        ,
        .good_frames    (good_frames),
        .bad_frames     (bad_frames),
        .dropped_frames (dropped_frames)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: expected FIFO contents plus where we are relative to frame boundaries.
    axis_beat_t q[$];
    bit synced;
    bit discarding;
    bit mid;
    bit exp_ovf;
    int m_good, m_bad, m_drop;

    task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        synced     = 1'b0;
        discarding = 1'b0;
        mid        = 1'b0;
        exp_ovf    = 1'b0;
        m_good     = 0;
        m_bad      = 0;
        m_drop     = 0;
    endtask

    task automatic model_step();
        int         free;
        axis_beat_t b;
        bit         wr;
        bit         trunc;
        wr      = 1'b0;
        trunc   = 1'b0;
        free    = DEPTH - q.size();
        exp_ovf = 1'b0;
        b = '{data: in_tdata, keep: in_tkeep, last: in_tlast, user: in_tuser};
        if (in_tvalid) begin
            if (!synced) begin
                synced = in_tlast;
            end else if (discarding) begin
                discarding = !in_tlast;
            end else if (free >= 2 || (free >= 1 && in_tlast)) begin
                wr  = 1'b1;
                mid = !in_tlast;
            end else if (!mid) begin
                exp_ovf    = 1'b1;
                m_drop++;
                discarding = !in_tlast;
            end else begin
                wr         = 1'b1;
                trunc      = 1'b1;
                b.last     = 1'b1;
                b.user     = 1'b1;
                exp_ovf    = 1'b1;
                m_drop++;
                discarding = 1'b1;
                mid        = 1'b0;
            end
        end
        if (wr && in_tlast && !trunc) begin
            if (in_tuser) m_bad++;
            else          m_good++;
        end
        if (out_tready && q.size() != 0) void'(q.pop_front());
        if (wr) q.push_back(b);
    endtask

    task automatic check_outputs();
        chk("out_tvalid", out_tvalid, q.size() != 0);
        if (q.size() != 0)
            chk("out_beat", {out_tdata, out_tkeep, out_tlast, out_tuser}, q[0]);
        chk("overflow", overflow, exp_ovf);
`ifdef CMAC_RX_STATS_EN
        chk("good_frames", good_frames, m_good);
        chk("bad_frames", bad_frames, m_bad);
        chk("dropped_frames", dropped_frames, m_drop);
`endif
    endtask

    task automatic tick();
        @(posedge rx_clk);
        if (resetn) model_step();
        @(negedge rx_clk);
        check_outputs();
    endtask

    task automatic beat(input bit v, input bit last, input bit user);
        for (int i = 0; i < AXIS_DATA_W / 32; i++) in_tdata[i*32 +: 32] = $urandom;
        in_tkeep  = {$urandom, $urandom};
        in_tvalid = v;
        in_tlast  = last;
        in_tuser  = user;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int len, input bit user_end);
        for (int i = 0; i < len; i++)
            beat(1'b1, i == len - 1, (i == len - 1) ? user_end : 1'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge rx_clk);
        chk("rst_tvalid", out_tvalid, 1'b0);
        chk("rst_payload", {out_tdata, out_tkeep, out_tlast, out_tuser}, '0);
        chk("rst_overflow", overflow, 1'b0);
`ifdef CMAC_RX_STATS_EN
        chk("rst_good", good_frames, 0);
        chk("rst_bad", bad_frames, 0);
        chk("rst_dropped", dropped_frames, 0);
`endif
        resetn = 1'b1;
        idle(2);

        // Stream joins mid-frame, then one clean 4-beat frame.
        out_tready = 1'b1;
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        frame(4, 1'b0);
        idle(3);

        // Back-to-back single-beat frames.
        repeat (20) frame(1, 1'b0);
        idle(3);

        // Stalled sink: a 20-beat frame is truncated at the 16th beat.
        out_tready = 1'b0;
        frame(20, 1'b0);
        idle(2);

        // Occupancy 15: 2-beat frame dropped whole, 1-beat frame fits.
        out_tready = 1'b1;
        idle(1);
        out_tready = 1'b0;
        frame(2, 1'b0);
        frame(1, 1'b0);
        idle(1);
        out_tready = 1'b1;
        idle(20);

        // Errored frame end is forwarded and counted as bad.
        frame(3, 1'b1);
        idle(4);

        // Reset mid-frame with 5 beats buffered.
        out_tready = 1'b0;
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        chk("async_rst_tvalid", out_tvalid, 1'b0);
        model_reset();
        in_tvalid = 1'b0;
        tick();
        resetn = 1'b1;
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        out_tready = 1'b1;
        frame(4, 1'b0);
        idle(5);

        // Random traffic, mostly-ready sink.
        for (int i = 0; i < 400; i++) begin
            out_tready = ($urandom_range(0, 3) != 0);
            beat($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 1'($urandom));
        end
        // Random traffic, mostly-stalled sink to provoke drops and truncations.
        for (int i = 0; i < 300; i++) begin
            out_tready = ($urandom_range(0, 3) == 0);
            beat($urandom_range(0, 9) < 8, $urandom_range(0, 5) == 0, 1'($urandom));
        end
        out_tready = 1'b1;
        idle(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
